// File: rtl/z80_bus_tracer.sv
// z80_bus_tracer: passive Z80 bus observer. Counts cycles and M1 fetches,
// records completed memory/IO transactions in a trace FIFO, and raises a
// sticky done on timeout, HALT or a write watchpoint hit.
// Build option: define Z80_TRACER_WATCH_EN to compile in the watchpoint logic.
module z80_bus_tracer #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int TRACE_DEPTH = 16,
  parameter int MAX_CYCLES  = 1_000_000,
  parameter int NUM_WATCH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_L,
  input  logic [ADDR_W-1:0]             addr_bus,
  input  logic [DATA_W-1:0]             data_in,
  input  logic [DATA_W-1:0]             data_out,
  input  logic                          M1_L,
  input  logic                          MREQ_L,
  input  logic                          IORQ_L,
  input  logic                          RD_L,
  input  logic                          WR_L,
  input  logic                          RFSH_L,
  input  logic                          HALT_L,
  input  logic [NUM_WATCH*ADDR_W-1:0]   watch_addr,
  input  logic [NUM_WATCH-1:0]          watch_en,
  input  logic                          trace_pop,
  output logic                          trace_valid,
  output logic [ADDR_W+DATA_W+1:0]      trace_entry,
  output logic [7:0]                    trace_ovf,
  output logic [31:0]                   cycle_cnt,
  output logic [31:0]                   m1_cnt,
  output logic                          done,
  output logic [1:0]                    done_cause,
  output logic [2:0]                    watch_idx
);

  localparam int          PW      = $clog2(TRACE_DEPTH);
  localparam int          EW      = ADDR_W + DATA_W + 2;
  localparam logic [31:0] TO_LAST = 32'(MAX_CYCLES - 1);

  logic              active, act_q, commit;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic              hold_io, hold_wr;
  logic              halt_q, m1_q, m1_cond, halt_cond, timeout;
  logic              watch_hit;
  logic [2:0]        watch_sel;

  logic [EW-1:0]     mem [TRACE_DEPTH];
  logic [EW-1:0]     last_q;
  logic [PW:0]       wr_ptr, rd_ptr;
  logic              empty, full, pop_ok, push_ok, drop;

  // Refresh cycles are excluded so they never reach the trace.
  assign active    = (!MREQ_L || !IORQ_L) && (!RD_L || !WR_L) && RFSH_L;
  assign commit    = act_q && !active && !done;
  assign m1_cond   = !M1_L && !MREQ_L;
  assign halt_cond = !HALT_L && halt_q;
  assign timeout   = (cycle_cnt == TO_LAST);

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop_ok  = trace_pop && !empty;
  assign push_ok = commit && (!full || pop_ok);
  assign drop    = commit && full && !pop_ok;

  assign trace_valid = !empty;
  assign trace_entry = empty ? last_q : mem[rd_ptr[PW-1:0]];

`ifdef Z80_TRACER_WATCH_EN
  // Lowest enabled slot matching a committed memory write wins.
  always_comb begin
    watch_hit = 1'b0;
    watch_sel = '0;
    for (int k = NUM_WATCH - 1; k >= 0; k--) begin
      if (watch_en[k] && (watch_addr[k*ADDR_W +: ADDR_W] == hold_addr)) begin
        watch_hit = 1'b1;
        watch_sel = 3'(k);
      end
    end
    if (!(commit && !hold_io && hold_wr)) watch_hit = 1'b0;
  end

  // Slot index captured together with the watchpoint stop.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L)                      watch_idx <= '0;
    else if (!done && watch_hit)     watch_idx <= watch_sel;
  end
`else
  wire unused_watch = ^{watch_addr, watch_en};
  assign watch_hit = 1'b0;
  assign watch_sel = '0;
  assign watch_idx = '0;
`endif

  // Bus sampling: holding register, previous-sample flags for edge detects.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      act_q     <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
      hold_io   <= 1'b0;
      hold_wr   <= 1'b0;
      halt_q    <= 1'b0;
      m1_q      <= 1'b0;
    end else begin
      act_q  <= active;
      halt_q <= !HALT_L;
      m1_q   <= m1_cond;
      if (active) begin
        hold_addr <= addr_bus;
        hold_io   <= !IORQ_L;
        hold_wr   <= !WR_L;
        hold_data <= !WR_L ? data_out : data_in;
      end
    end
  end

  // Trace FIFO; a pop in the same cycle frees room for a push while full.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_q    <= '0;
      trace_ovf <= '0;
      for (int i = 0; i < TRACE_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pop_ok) begin
        last_q <= mem[rd_ptr[PW-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok) begin
        mem[wr_ptr[PW-1:0]] <= {hold_io, hold_wr, hold_addr, hold_data};
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (drop && (trace_ovf != 8'hFF)) trace_ovf <= trace_ovf + 1'b1;
    end
  end

  // Counters and sticky stop with watchpoint > halt > timeout priority.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      cycle_cnt  <= '0;
      m1_cnt     <= '0;
      done       <= 1'b0;
      done_cause <= 2'b00;
    end else if (!done) begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (m1_cond && !m1_q) m1_cnt <= m1_cnt + 1'b1;
      if (watch_hit) begin
        done       <= 1'b1;
        done_cause <= 2'b11;
      end else if (halt_cond) begin
        done       <= 1'b1;
        done_cause <= 2'b10;
      end else if (timeout) begin
        done       <= 1'b1;
        done_cause <= 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_z80_bus_tracer.sv
// Directed bench for z80_bus_tracer: reset, trace capture, overflow,
// halt stop, watchpoint/timeout priority and mid-transaction reset.
module tb_z80_bus_tracer;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int MAXC   = 50;
  localparam int NW     = 4;
  localparam int EW     = ADDR_W + DATA_W + 2;

  logic                 clk = 1'b0;
  logic                 rst_L;
  logic [ADDR_W-1:0]    addr_bus;
  logic [DATA_W-1:0]    data_in, data_out;
  logic                 M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, HALT_L;
  logic [NW*ADDR_W-1:0] watch_addr;
  logic [NW-1:0]        watch_en;
  logic                 trace_pop;
  logic                 trace_valid;
  logic [EW-1:0]        trace_entry;
  logic [7:0]           trace_ovf;
  logic [31:0]          cycle_cnt, m1_cnt;
  logic                 done;
  logic [1:0]           done_cause;
  logic [2:0]           watch_idx;

  int n_chk = 0;
  int n_err = 0;

  z80_bus_tracer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TRACE_DEPTH(DEPTH),
    .MAX_CYCLES(MAXC), .NUM_WATCH(NW)
  ) dut (
    .clk(clk), .rst_L(rst_L), .addr_bus(addr_bus), .data_in(data_in),
    .data_out(data_out), .M1_L(M1_L), .MREQ_L(MREQ_L), .IORQ_L(IORQ_L),
    .RD_L(RD_L), .WR_L(WR_L), .RFSH_L(RFSH_L), .HALT_L(HALT_L),
    .watch_addr(watch_addr), .watch_en(watch_en), .trace_pop(trace_pop),
    .trace_valid(trace_valid), .trace_entry(trace_entry), .trace_ovf(trace_ovf),
    .cycle_cnt(cycle_cnt), .m1_cnt(m1_cnt), .done(done),
    .done_cause(done_cause), .watch_idx(watch_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running required finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    M1_L = 1'b1; MREQ_L = 1'b1; IORQ_L = 1'b1; RD_L = 1'b1; WR_L = 1'b1;
    RFSH_L = 1'b1; HALT_L = 1'b1; trace_pop = 1'b0;
  endtask

  task automatic do_reset();
    bus_idle();
    addr_bus = '0; data_in = '0; data_out = '0;
    rst_L = 1'b0;
    repeat (3) step();
    rst_L = 1'b1;
  endtask

  function automatic logic [EW-1:0] ent(input logic io, input logic wr,
                                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    return {io, wr, a, d};
  endfunction

  logic [EW-1:0] exp_q[$];
  logic [1:0]    exp_cause;
  logic [2:0]    exp_idx;

  initial begin
    watch_addr = '0;
    watch_en   = '0;

    // ---- reset state and idle counting ----
    do_reset();
    check("rst_valid", trace_valid, 0);
    check("rst_entry", trace_entry, 0);
    check("rst_ovf",   trace_ovf, 0);
    check("rst_cyc",   cycle_cnt, 0);
    check("rst_m1",    m1_cnt, 0);
    check("rst_done",  done, 0);
    check("rst_cause", done_cause, 0);
    check("rst_widx",  watch_idx, 0);
    repeat (5) step();
    check("idle_cyc5", cycle_cnt, 5);

    // refresh cycle never commits
    MREQ_L = 0; RD_L = 0; RFSH_L = 0; addr_bus = 16'h0077;
    step();
    bus_idle();
    step();
    check("rfsh_valid", trace_valid, 0);

    // single memory write 0x5A -> 0x1234 (data_in differs to prove selection)
    MREQ_L = 0; WR_L = 0; addr_bus = 16'h1234; data_out = 8'h5A; data_in = 8'hC3;
    step();
    check("wr_valid_pre", trace_valid, 0);
    bus_idle();
    step();
    check("wr_valid",  trace_valid, 1);
    check("wr_entry",  trace_entry, ent(1'b0, 1'b1, 16'h1234, 8'h5A));
    check("wr_m1",     m1_cnt, 0);

    // ---- FIFO overflow: 20 IO reads, no pops ----
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      IORQ_L = 0; RD_L = 0; addr_bus = 16'h0100 + 16'(i); data_in = 8'h10 + 8'(i);
      data_out = 8'hFF;
      step();
      bus_idle();
      step();
      if (i < DEPTH) exp_q.push_back(ent(1'b1, 1'b0, 16'h0100 + 16'(i), 8'h10 + 8'(i)));
    end
    check("ovf_after20", trace_ovf, 4);
    check("ovf_head",    trace_entry, exp_q[0]);
    check("ovf_cyc",     cycle_cnt, 40);
    // push while full with simultaneous pop: nothing dropped
    IORQ_L = 0; RD_L = 0; addr_bus = 16'h0200; data_in = 8'hEE;
    step();
    bus_idle();
    trace_pop = 1'b1;
    step();
    trace_pop = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(ent(1'b1, 1'b0, 16'h0200, 8'hEE));
    check("ovf_pushpop", trace_ovf, 4);
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("fifo_e%0d", k), trace_entry, exp_q[k]);
      trace_pop = 1'b1;
      step();
      trace_pop = 1'b0;
    end
    check("fifo_empty", trace_valid, 0);
    check("fifo_hold",  trace_entry, exp_q[DEPTH-1]);
    trace_pop = 1'b1;
    step();
    trace_pop = 1'b0;
    check("pop_empty_ign", trace_entry, exp_q[DEPTH-1]);

    // ---- M1 counting and halt stop ----
    do_reset();
    M1_L = 0; MREQ_L = 0; RD_L = 0; addr_bus = 16'h0038; data_in = 8'h3E; data_out = 8'hFF;
    step();
    step();
    bus_idle();
    step();
    M1_L = 0; IORQ_L = 0;
    step();
    bus_idle();
    step();
    check("m1_once", m1_cnt, 1);
    HALT_L = 0;
    step();
    HALT_L = 1;
    step();
    check("halt1_nostop", done, 0);
    HALT_L = 0;
    step();
    step();
    HALT_L = 1;
    check("halt_done",  done, 1);
    check("halt_cause", done_cause, 2'b10);
    check("halt_cyc",   cycle_cnt, 9);
    M1_L = 0; MREQ_L = 0; RD_L = 0; addr_bus = 16'h0040; data_in = 8'h00;
    step();
    bus_idle();
    step();
    check("frz_cyc",   cycle_cnt, 9);
    check("frz_m1",    m1_cnt, 1);
    check("frz_cause", done_cause, 2'b10);
    check("frz_entry", trace_entry, ent(1'b0, 1'b0, 16'h0038, 8'h3E));
    trace_pop = 1'b1;
    step();
    trace_pop = 1'b0;
    check("frz_nopush", trace_valid, 0);

    // ---- watchpoint on the timeout cycle ----
    watch_addr = {16'h8000, 16'h4444, 16'h8000, 16'h8000};
    watch_en   = 4'b1010;
    do_reset();
    repeat (48) step();
    MREQ_L = 0; WR_L = 0; addr_bus = 16'h8000; data_out = 8'h99;
    step();
    check("pre_to_done", done, 0);
    check("pre_to_cyc",  cycle_cnt, 49);
    bus_idle();
    step();
`ifdef Z80_TRACER_WATCH_EN
    exp_cause = 2'b11; exp_idx = 3'd1;
`else
    exp_cause = 2'b01; exp_idx = 3'd0;
`endif
    check("wt_done",  done, 1);
    check("wt_cause", done_cause, exp_cause);
    check("wt_idx",   watch_idx, exp_idx);
    check("wt_cyc",   cycle_cnt, MAXC);
    check("wt_entry", trace_entry, ent(1'b0, 1'b1, 16'h8000, 8'h99));
    check("wt_valid", trace_valid, 1);

    // ---- reset pulse during an active read ----
    watch_en = '0;
    do_reset();
    M1_L = 0; MREQ_L = 0; RD_L = 0; addr_bus = 16'h0100; data_in = 8'hAA;
    step();
    check("mid_m1_pre", m1_cnt, 1);
    rst_L = 1'b0;
    #2;
    check("mid_m1_rst", m1_cnt, 0);
    step();
    bus_idle();
    step();
    rst_L = 1'b1;
    step();
    step();
    check("mid_valid", trace_valid, 0);
    check("mid_m1",    m1_cnt, 0);
    check("mid_cyc",   cycle_cnt, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/z80_bus_tracer.md
# z80_bus_tracer

Parametrised Z80 bus observer for the system bench and FPGA debug builds. It sits beside the `z80` core on the shared address and data bus, alongside memory and ports. It counts clock cycles and M1 fetches, captures completed memory and IO transactions into a trace FIFO, and raises a sticky `done` on timeout, HALT or a watchpoint hit. It replaces fixed-length cycle loops with a run-until-event mechanism and adds a bounded transaction trace.

## Interface
- `ADDR_W`, 16, address bus width.
- `DATA_W`, 8, data bus width.
- `TRACE_DEPTH`, 16, trace FIFO entries; must be a power of two, ≥2.
- `MAX_CYCLES`, 1_000_000, timeout in counted cycles; must be ≥1.
- `NUM_WATCH`, 4, number of write watchpoints, 1..8.
- `clk` in 1: single clock; all sampling on its rising edge.
- `rst_L` in 1: asynchronous, active-low reset.
- `addr_bus` in ADDR_W: CPU address.
- `data_in` in DATA_W: data driven toward the CPU (reads).
- `data_out` in DATA_W: data driven by the CPU (writes).
- `M1_L`, `MREQ_L`, `IORQ_L`, `RD_L`, `WR_L`, `RFSH_L`, `HALT_L` in 1 each: Z80 control strobes, all active-low.
- `watch_addr` in NUM_WATCH*ADDR_W: watchpoint addresses; slot k occupies bits [k*ADDR_W +: ADDR_W].
- `watch_en` in NUM_WATCH: per-slot enable.
- `trace_pop` in 1: consume the head trace entry.
- `trace_valid` out 1: FIFO is non-empty.
- `trace_entry` out ADDR_W+DATA_W+2: head entry, packed as {is_io, is_write, addr, data}.
- `trace_ovf` out 8: count of dropped entries, saturating at 255.
- `cycle_cnt` out 32: number of counted cycles.
- `m1_cnt` out 32: number of opcode fetches.
- `done` out 1: sticky stop flag.
- `done_cause` out 2: 00 none, 01 timeout, 10 halt, 11 watchpoint.
- `watch_idx` out 3: index of the slot that hit; valid when `done_cause`=11.

## Operation
- Reset value of every output, and of all internal state, is zero. The FIFO is empty.
- `active` is true on a sample where (!MREQ_L | !IORQ_L) & (!RD_L | !WR_L) & RFSH_L.
  - On each active sample, a holding register latches addr_bus, is_io=!IORQ_L and is_write=!WR_L.
  - The data field takes data_out when writing and data_in when reading. The last active sample wins.
- A transaction commits on the first sample with `active`=0 after a sample with `active`=1.
  - The committed entry is the holding register contents.
  - A refresh cycle (RFSH_L low) is never active and never commits.
- FIFO push on commit:
  - If the FIFO is full, the entry is dropped and `trace_ovf` increments, saturating at 255.
  - If `trace_pop` is asserted in the same cycle the FIFO is full, both the pop and the push are accepted, so nothing is dropped.
  - `trace_pop` while empty is ignored.
- `m1_cnt` increments on a sample with M1_L=0 & MREQ_L=0 when the previous sample was not in that condition. Interrupt-acknowledge cycles (M1_L with IORQ_L) are not counted.
- `cycle_cnt` increments on every cycle while `done`=0.
- Halt condition: HALT_L sampled low on 2 consecutive cycles.
- Watch condition: a committed memory write (is_io=0, is_write=1) whose addr equals an enabled slot.
  - When more than one slot matches, `watch_idx` = the lowest matching index.
- Timeout condition: `cycle_cnt` reaches MAX_CYCLES-1 while incrementing.
- Stop:
  - When any stop condition occurs with `done`=0, `done` sets and `done_cause` records the cause.
  - Cause priority when simultaneous: watchpoint > halt > timeout.
  - After `done` is set, the counters and `done_cause` freeze.
  - After `done` is set, new commits are ignored. The committing watchpoint entry itself is still pushed.
  - The FIFO stays readable after `done`.
  - Only `rst_L` clears `done`.
- Reset assertion mid-transaction discards the holding register. No commit occurs on reset release.

## Timing
- Commit-to-`trace_valid` latency: 1 cycle. The entry is visible on the cycle after the commit sample.
- Pop: `trace_entry` advances on the cycle after a `trace_pop` edge. `trace_entry` holds its last value when the FIFO is empty.
- `done` rises 1 cycle after the stop-condition sample. `cycle_cnt` equals MAX_CYCLES on a timeout stop.
- `m1_cnt`, `trace_ovf`: registered, 1-cycle latency.
- FIFO pointers are log2(TRACE_DEPTH)+1 bits, so full and empty are distinguished by the wrap bit. The pointers wrap modulo 2·TRACE_DEPTH.

## Configuration
- `Z80_TRACER_WATCH_EN`: watchpoint logic is compiled in.
- Without the macro:
  - `watch_addr` and `watch_en` are ignored.
  - `watch_idx` is tied to 0.
  - Cause 11 never occurs.
  - All other behaviour is identical.

## Test plan
- Reset: rst_L=0 for 3 cycles, then release with idle bus. Required: all outputs 0; `cycle_cnt`=5 after 5 cycles.
- Single memory write of 0x5A to 0x1234, then idle. Required: `trace_valid`=1 one cycle after commit; `trace_entry`={0,1,16'h1234,8'h5A}.
- Drive 20 IO reads with no pops, TRACE_DEPTH=16. Required: 16 entries are held and `trace_ovf`=4. Then push while full with simultaneous pop: required `trace_ovf` stays 4.
- HALT_L low for 1 cycle, then high: required no stop. HALT_L then low for 2 cycles: required `done`=1 and `done_cause`=10; counters frozen thereafter.
- With the macro defined: slots 1 and 3 both set to 0x8000 and enabled; write to 0x8000 on the same cycle as timeout (MAX_CYCLES=50). Required: `done_cause`=11 and `watch_idx`=1. Without the macro: `done_cause`=01.
- Pulse rst_L low during an active read. Required: no entry is pushed after release and `m1_cnt`=0.
